// File: rtl/rr_grant_arbiter.sv
// Round-robin / fixed-priority grant arbiter with a held valid/ready grant,
// an end-of-sweep group-release pulse, a sweep restart and a completed-grant counter.
module rr_grant_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               refresh_i,
  input  logic               mode_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               gnt_valid_o,
  output logic               grp_release_o,
  output logic [CNT_W-1:0]   gnt_cnt_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic               rel_q, rel_d;
  logic               fixed_q, fixed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] mreq;
  logic [NUM_REQ-1:0] rem;
  logic [ADDR_W-1:0]  win;

  // Index of the lowest set bit; scanning downwards lets the lowest hit win.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    fixed_d = fixed_q;
    cnt_d   = cnt_q;
    rel_d   = 1'b0;

    mreq = req_i & mask_q;
    if (mode_i || (mreq == '0)) win = lowest_idx(req_i);
    else                        win = lowest_idx(mreq);

    // Requesters still waiting in the current sweep, judged by the held grant's mode.
    if (fixed_q) rem = req_i & ~gnt_q;
    else         rem = req_i & mask_q & ~gnt_q;

    unique case (state_q)
      IDLE: begin
        if (refresh_i) begin
          mask_d = '1;
        end else if (enable_i && (req_i != '0)) begin
          gnt_d   = '0;
          gnt_d[win] = 1'b1;
          addr_d  = win;
          valid_d = 1'b1;
          fixed_d = mode_i;
          state_d = GRANT;
          if (!mode_i) mask_d = {NUM_REQ{1'b1}} << (int'(win) + 1);
        end
      end
      GRANT: begin
        if (gnt_ready_i) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          rel_d   = (rem == '0);
          state_d = IDLE;
        end
        if (refresh_i) mask_d = '1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mask_q  <= '1;
      gnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      rel_q   <= 1'b0;
      fixed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      state_q <= state_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      rel_q   <= rel_d;
      fixed_q <= fixed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign addr_o        = addr_q;
  assign gnt_valid_o   = valid_q;
  assign grp_release_o = rel_q;
  assign gnt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: vector table, hand-written corner
// sequences, 4/16-wide builds and a randomized run against a pointer-based model.
module tb_rr_grant_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i, refresh_i, mode_i, gnt_ready_i;
  logic [7:0]  req8;
  logic [3:0]  req4;
  logic [15:0] req16;

  logic [7:0]  gnt8;
  logic [2:0]  addr8;
  logic        valid8, rel8;
  logic [15:0] cnt8;

  logic [3:0]  gnt4;
  logic [1:0]  addr4;
  logic        valid4, rel4;
  logic [15:0] cnt4;

  logic [15:0] gnt16;
  logic [3:0]  addr16;
  logic        valid16, rel16;
  logic [15:0] cnt16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  rr_grant_arbiter #(.NUM_REQ(8), .ADDR_W(3), .CNT_W(16)) dut8 (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .refresh_i(refresh_i),
    .mode_i(mode_i), .req_i(req8), .gnt_ready_i(gnt_ready_i), .gnt_o(gnt8),
    .addr_o(addr8), .gnt_valid_o(valid8), .grp_release_o(rel8), .gnt_cnt_o(cnt8));

  rr_grant_arbiter #(.NUM_REQ(4), .ADDR_W(2), .CNT_W(16)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .refresh_i(refresh_i),
    .mode_i(mode_i), .req_i(req4), .gnt_ready_i(gnt_ready_i), .gnt_o(gnt4),
    .addr_o(addr4), .gnt_valid_o(valid4), .grp_release_o(rel4), .gnt_cnt_o(cnt4));

  rr_grant_arbiter #(.NUM_REQ(16), .ADDR_W(4), .CNT_W(16)) dut16 (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .refresh_i(refresh_i),
    .mode_i(mode_i), .req_i(req16), .gnt_ready_i(gnt_ready_i), .gnt_o(gnt16),
    .addr_o(addr16), .gnt_valid_o(valid16), .grp_release_o(rel16), .gnt_cnt_o(cnt16));

  typedef struct {
    logic [7:0]  req;
    logic        mode;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_addr;
    logic        exp_rel;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    enable_i    = 1'b0;
    refresh_i   = 1'b0;
    mode_i      = 1'b0;
    gnt_ready_i = 1'b0;
    req8        = '0;
    req4        = '0;
    req16       = '0;
    reset_i     = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  // Reference: a "last granted" pointer; round robin searches upward from it, then wraps.
  function automatic int model_pick(input logic [7:0] req, input bit fixed, input int last);
    if (!fixed) begin
      for (int k = last + 1; k < 8; k++) if (req[k]) return k;
    end
    for (int k = 0; k < 8; k++) if (req[k]) return k;
    return -1;
  endfunction

  initial begin
    vecs[0]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd0};
    vecs[1]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd1};
    vecs[2]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 16'd1};
    vecs[3]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 16'd2};
    vecs[4]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 16'd2};
    vecs[5]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 16'd3};
    vecs[6]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 16'd3};
    vecs[7]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 16'd4};
    vecs[8]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd4};
    vecs[9]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd5};
    vecs[10] = '{8'h18, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 16'd5};
    vecs[11] = '{8'h18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 16'd6};
    vecs[12] = '{8'h18, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 16'd6};
    vecs[13] = '{8'h18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 16'd7};
    vecs[14] = '{8'h18, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 16'd7};
    vecs[15] = '{8'h18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 16'd8};

    apply_reset();
    check("reset_gnt", 32'(gnt8), 32'h0);
    check("reset_valid", 32'(valid8), 32'h0);
    check("reset_addr", 32'(addr8), 32'h0);
    check("reset_rel", 32'(rel8), 32'h0);
    check("reset_cnt", 32'(cnt8), 32'h0);

    // Round-robin sweep over 8'hA5, then fixed priority over 8'h18.
    enable_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req8        = vecs[i].req;
      mode_i      = vecs[i].mode;
      gnt_ready_i = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(valid8), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_gnt", i), 32'(gnt8),
            vecs[i].exp_valid ? (32'h1 << vecs[i].exp_addr) : 32'h0);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_addr", i), 32'(addr8), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_rel", i), 32'(rel8), 32'(vecs[i].exp_rel));
      check($sformatf("vec%0d_cnt", i), 32'(cnt8), 32'(vecs[i].exp_cnt));
    end

    // Stall: grant held through req withdrawal and enable low.
    apply_reset();
    enable_i = 1'b1;
    req8 = 8'h04;
    step();
    check("stall_first_gnt", 32'(gnt8), 32'h04);
    req8 = 8'h00;
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d_gnt", i), 32'(gnt8), 32'h04);
      check($sformatf("stall%0d_addr", i), 32'(addr8), 32'h2);
      check($sformatf("stall%0d_valid", i), 32'(valid8), 32'h1);
    end
    gnt_ready_i = 1'b1;
    step();
    gnt_ready_i = 1'b0;
    check("stall_hs_valid", 32'(valid8), 32'h0);
    check("stall_hs_gnt", 32'(gnt8), 32'h0);
    check("stall_hs_cnt", 32'(cnt8), 32'h1);
    check("stall_hs_addr_kept", 32'(addr8), 32'h2);

    // Refresh in IDLE beats arbitration and restarts the sweep.
    apply_reset();
    enable_i = 1'b1;
    gnt_ready_i = 1'b1;
    req8 = 8'h13;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rf_grant%0d_addr", i), 32'(addr8), (i == 2) ? 32'd4 : 32'(i));
      step();
    end
    check("rf_sweep_rel", 32'(rel8), 32'h1);
    refresh_i = 1'b1;
    step();
    refresh_i = 1'b0;
    check("rf_no_grant", 32'(valid8), 32'h0);
    step();
    check("rf_after_addr", 32'(addr8), 32'h0);
    check("rf_after_valid", 32'(valid8), 32'h1);
    step();
    step();
    check("rf_next_addr", 32'(addr8), 32'h1);

    // Asynchronous reset while a grant is presented.
    apply_reset();
    enable_i = 1'b1;
    gnt_ready_i = 1'b1;
    req8 = 8'h02;
    step();
    step();
    gnt_ready_i = 1'b0;
    req8 = 8'h04;
    step();
    check("ar_pre_valid", 32'(valid8), 32'h1);
    #2 reset_i = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt8), 32'h0);
    check("ar_valid", 32'(valid8), 32'h0);
    check("ar_addr", 32'(addr8), 32'h0);
    check("ar_cnt", 32'(cnt8), 32'h0);
    check("ar_rel", 32'(rel8), 32'h0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    req8 = 8'h80;
    gnt_ready_i = 1'b1;
    step();
    check("ar_gnt7", 32'(gnt8), 32'h80);
    step();
    check("ar_rel7", 32'(rel8), 32'h1);
    req8 = 8'h81;
    step();
    check("ar_wrap_addr", 32'(addr8), 32'h0);

    // Narrow and wide builds, all requests active.
    apply_reset();
    enable_i = 1'b1;
    gnt_ready_i = 1'b1;
    req4 = 4'hF;
    req16 = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      step();
      check($sformatf("n4_k%0d_addr", k), 32'(addr4), 32'(k % 4));
      check($sformatf("n16_k%0d_addr", k), 32'(addr16), 32'(k % 16));
      if (k == 0) check("n4_first_valid", 32'(valid4), 32'h1);
      step();
    end

    // Randomized run against the pointer model.
    begin
      bit          m_valid = 0;
      bit          m_fixed = 0;
      bit          m_rel = 0;
      bit          any;
      int          m_idx = 0;
      int          m_last = -1;
      int          w;
      logic [15:0] m_cnt = '0;
      apply_reset();
      for (int c = 0; c < 600; c++) begin
        req8        = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        enable_i    = ($urandom_range(0, 3) != 0);
        refresh_i   = ($urandom_range(0, 9) == 0);
        mode_i      = ($urandom_range(0, 3) == 0);
        gnt_ready_i = ($urandom_range(0, 2) != 0);
        @(posedge clk_i);
        m_rel = 0;
        if (!m_valid) begin
          if (refresh_i) m_last = -1;
          else if (enable_i && req8 != 0) begin
            w = model_pick(req8, mode_i, m_last);
            m_valid = 1;
            m_idx = w;
            m_fixed = mode_i;
            if (!mode_i) m_last = w;
          end
        end else begin
          if (gnt_ready_i) begin
            any = 0;
            for (int k = 0; k < 8; k++)
              if (req8[k] && k != m_idx && (m_fixed || k > m_last)) any = 1;
            m_rel = !any;
            m_valid = 0;
            m_cnt++;
          end
          if (refresh_i) m_last = -1;
        end
        #1;
        check($sformatf("rnd%0d_valid", c), 32'(valid8), 32'(m_valid));
        check($sformatf("rnd%0d_gnt", c), 32'(gnt8), m_valid ? (32'h1 << m_idx) : 32'h0);
        check($sformatf("rnd%0d_addr", c), 32'(addr8), 32'(m_idx));
        check($sformatf("rnd%0d_rel", c), 32'(rel8), 32'(m_rel));
        check($sformatf("rnd%0d_cnt", c), 32'(cnt8), 32'(m_cnt));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
